// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect sequencer: compares EX branch/jump resolution with the
// fetch-time prediction, drives flush + PC redirect into IF, and owns a bimodal BHT.
module branch_redirect_ctrl #(
   parameter int BHT_ENTRIES  = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        pred_taken_o,
   input  logic        res_valid,
   input  logic        res_is_branch,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   input  logic        res_pred_taken,
   input  logic [31:0] res_pred_target,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready,
   output logic        flush_o,
   output logic        busy_o,
   output logic [31:0] mispredict_cnt_o
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] drain_q, drain_d;
   logic [31:0]      rpc_q, rpc_d;
   logic [31:0]      mcnt_q, mcnt_d;
   logic [1:0]       bht_q [BHT_ENTRIES];

   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] res_idx;
   logic             accept;
   logic             mispredict;
   logic             unused_lookup;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken) begin
         return (cnt == 2'b11) ? cnt : cnt + 2'd1;
      end
      return (cnt == 2'b00) ? cnt : cnt - 2'd1;
   endfunction

   assign lookup_idx    = lookup_pc[IDX_W+1:2];
   assign res_idx       = res_pc[IDX_W+1:2];
   assign unused_lookup = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

   // Read is not bypassed: an update lands at the edge and is seen the cycle after.
   assign pred_taken_o = bht_q[lookup_idx][1];

   // Resolves arriving outside IDLE are wrong-path and must not touch any state.
   assign accept     = res_valid && (state_q == IDLE);
   assign mispredict = (res_taken != res_pred_taken) ||
                       (res_taken && res_pred_taken && (res_target != res_pred_target));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (accept && res_is_branch) begin
         bht_q[res_idx] <= sat_update(bht_q[res_idx], res_taken);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         drain_q <= '0;
         rpc_q   <= '0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         rpc_q   <= rpc_d;
         mcnt_q  <= mcnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      drain_d          = drain_q;
      rpc_d            = rpc_q;
      mcnt_d           = mcnt_q;
      redirect_valid_o = 1'b0;
      flush_o          = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && mispredict) begin
               state_d = REDIRECT;
               rpc_d   = res_taken ? res_target : res_pc + 32'd4;
               mcnt_d  = mcnt_q + 32'd1;
            end
         end
         REDIRECT: begin
            redirect_valid_o = 1'b1;
            flush_o          = 1'b1;
            if (redirect_ready) begin
               if (FLUSH_CYCLES == 1) begin
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
                  drain_d = CNT_W'(FLUSH_CYCLES - 1);
               end
            end
         end
         DRAIN: begin
            flush_o = 1'b1;
            drain_d = drain_q - CNT_W'(1);
            if (drain_q == CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o           = (state_q != IDLE);
   assign redirect_pc_o    = rpc_q;
   assign mispredict_cnt_o = mcnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios followed by
// randomized resolves, checked against a queue/array reference model.
module tb_branch_redirect_ctrl;

   localparam int BHT   = 64;
   localparam int FLUSH = 2;

   logic        clk;
   logic        rst;
   logic [31:0] lookup_pc;
   logic        pred_taken_o;
   logic        res_valid;
   logic        res_is_branch;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic        res_pred_taken;
   logic [31:0] res_pred_target;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        redirect_ready;
   logic        flush_o;
   logic        busy_o;
   logic [31:0] mispredict_cnt_o;

   branch_redirect_ctrl #(.BHT_ENTRIES(BHT), .FLUSH_CYCLES(FLUSH)) dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken_o(pred_taken_o),
      .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
      .res_taken(res_taken), .res_target(res_target), .res_pred_taken(res_pred_taken),
      .res_pred_target(res_pred_target), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .redirect_ready(redirect_ready), .flush_o(flush_o),
      .busy_o(busy_o), .mispredict_cnt_o(mispredict_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: counters as plain integers, redirect as pending flag plus
   // remaining flush cycles after the handshake.
   int          mbht [BHT];
   bit          mpend;
   int          mleft;
   logic [31:0] mcnt;
   logic [31:0] mrpc;
   logic [31:0] expq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx(input logic [31:0] pc);
      return int'((pc >> 2) % BHT);
   endfunction

   task automatic model_reset();
      foreach (mbht[i]) mbht[i] = 1;
      mpend = 1'b0;
      mleft = 0;
      mcnt  = '0;
      mrpc  = '0;
      expq.delete();
   endtask

   task automatic model_step();
      int i;
      if (rst) begin
         model_reset();
      end else if (mpend) begin
         if (redirect_ready) begin
            mpend = 1'b0;
            mleft = FLUSH - 1;
         end
      end else if (mleft > 0) begin
         mleft--;
      end else if (res_valid) begin
         if (res_is_branch) begin
            i = idx(res_pc);
            if (res_taken) mbht[i] = (mbht[i] < 3) ? mbht[i] + 1 : 3;
            else           mbht[i] = (mbht[i] > 0) ? mbht[i] - 1 : 0;
         end
         if ((res_taken != res_pred_taken) ||
             (res_taken && res_target != res_pred_target)) begin
            mpend = 1'b1;
            mrpc  = res_taken ? res_target : res_pc + 32'd4;
            mcnt  = mcnt + 32'd1;
            expq.push_back(mrpc);
         end
      end
   endtask

   task automatic step(input logic r, input logic [31:0] lpc, input logic rv, input logic rb,
                       input logic [31:0] rp, input logic rt, input logic [31:0] tg,
                       input logic pt, input logic [31:0] ptg, input logic rdy);
      @(negedge clk);
      rst = r; lookup_pc = lpc; res_valid = rv; res_is_branch = rb; res_pc = rp;
      res_taken = rt; res_target = tg; res_pred_taken = pt; res_pred_target = ptg;
      redirect_ready = rdy;
      #1;
      chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, mbht[idx(lookup_pc)] >= 2});
      chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, mpend});
      chk("flush", {31'd0, flush_o}, {31'd0, mpend || mleft > 0});
      chk("busy", {31'd0, busy_o}, {31'd0, mpend || mleft > 0});
      chk("mispredict_cnt", mispredict_cnt_o, mcnt);
      chk("redirect_pc_hold", redirect_pc_o, mrpc);
      model_step();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
   endtask

   // Monitor: every completed handshake must match the oldest expected redirect.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b0 && redirect_valid_o === 1'b1 && redirect_ready === 1'b1) begin
            if (expq.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL redirect_unexpected: got pc %0h expected no redirect", redirect_pc_o);
            end else begin
               chk("redirect_pc", redirect_pc_o, expq.pop_front());
            end
         end
      end
   end

   logic [31:0] pool [6];

   initial begin
      logic [31:0] lpc, rp, tg, ptg;
      logic        rt, pt;
      rst = 1'b1; lookup_pc = '0; res_valid = 1'b0; res_is_branch = 1'b0; res_pc = '0;
      res_taken = 1'b0; res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
      redirect_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      // Training: 01 -> 10 -> 11 -> 11 with correct predictions
      idle(1, 1'b1);
      repeat (3) step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180, 1'b1);
      idle(2, 1'b1);
      // BEQ taken mispredict, immediate ready
      step(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h180, 1'b0, 32'h0, 1'b1);
      idle(4, 1'b1);
      // Not-taken mispredict, ready low for 3 cycles
      step(1'b0, 32'h300, 1'b1, 1'b1, 32'h300, 1'b0, 32'h380, 1'b1, 32'h380, 1'b0);
      idle(3, 1'b0);
      idle(4, 1'b1);
      // JALR target mismatch, BHT untouched
      step(1'b0, 32'h400, 1'b1, 1'b0, 32'h400, 1'b1, 32'h4000, 1'b1, 32'h4004, 1'b1);
      idle(4, 1'b1);
      // Wrong-path resolves during REDIRECT and DRAIN
      step(1'b0, 32'h100, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
      repeat (2) step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      repeat (2) step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
      idle(3, 1'b1);
      // Reset while in REDIRECT
      step(1'b0, 32'h100, 1'b1, 1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle(3, 1'b1);
      // PC+4 wrap
      step(1'b0, 32'hFFFFFFFC, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1);
      idle(4, 1'b1);

      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
      pool[3] = 32'h300; pool[4] = 32'hFFFFFFFC; pool[5] = 32'h1100;
      for (int n = 0; n < 3000; n++) begin
         lpc = pool[$urandom_range(0, 5)];
         rp  = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 5)];
         rt  = 1'($urandom_range(0, 1));
         tg  = {$urandom_range(0, 7), 2'b00} + 32'h1000;
         pt  = ($urandom_range(0, 3) == 0) ? ~rt : rt;
         ptg = ($urandom_range(0, 4) == 0) ? tg + 32'd4 : tg;
         step(($urandom_range(0, 199) == 0), lpc, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), rp, rt, tg, pt, ptg,
              ($urandom_range(0, 9) < 6));
      end
      idle(10, 1'b1);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow redirection for the 5-stage core.
- Takes branch/jump resolution results from the execute-stage branch/jump decision logic and compares them with the prediction made at fetch.
- On a mispredict it drives a front-end flush and a PC redirect handshake into IF.
- Owns a bimodal branch history table (BHT) that IF queries each cycle; keeps a mispredict counter for performance debug.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of 2, ≥2.
- FLUSH_CYCLES, 2, total cycles flush_o is asserted per mispredict, including the redirect cycle; ≥1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- lookup_pc  in  32  IF-stage PC to predict.
- pred_taken_o  out  1  BHT prediction for lookup_pc.
- res_valid  in  1  EX has a resolved control-flow instruction this cycle.
- res_is_branch  in  1  1 = conditional branch (updates BHT); 0 = JAL/JALR.
- res_pc  in  32  PC of the resolved instruction.
- res_taken  in  1  actual outcome (always 1 for jumps).
- res_target  in  32  actual taken target (pc+imm).
- res_pred_taken  in  1  prediction that travelled down with the instruction.
- res_pred_target  in  32  predicted target (ignored when res_pred_taken=0).
- redirect_valid_o  out  1  redirect request to IF.
- redirect_pc_o  out  32  PC to fetch next.
- redirect_ready  in  1  IF accepts the redirect this cycle.
- flush_o  out  1  kill IF/ID contents.
- busy_o  out  1  FSM not in IDLE.
- mispredict_cnt_o  out  32  number of mispredicts accepted since reset.

Behaviour:
- Reset: state=IDLE; all outputs 0 except pred_taken_o, which reflects table contents. Every BHT entry = 2'b01 (weakly not-taken). Drain counter 0; mispredict_cnt_o 0. Reset mid-operation aborts any redirect: the pending request is dropped and no handshake completes.
- BHT index = pc[log2(BHT_ENTRIES)+1:2].
- pred_taken_o = bit[1] of the entry indexed by lookup_pc. Combinational, no bypass: a same-cycle update to the same index is visible the next cycle.
- Accepted resolve: res_valid=1 while state=IDLE. res_valid in any other state is wrong-path: ignored, with no BHT update and no count.
- BHT update (accepted resolve with res_is_branch=1): saturating counter, +1 if taken, -1 if not; 2'b11 and 2'b00 hold. Takes effect at the next edge.
- Mispredict = (res_taken != res_pred_taken) OR (res_taken AND res_pred_taken AND res_target != res_pred_target).
- Correct prediction: no outputs change; state stays IDLE.
- Redirect PC (registered): res_target if res_taken, else res_pc+4. Computed mod 2^32, so 0xFFFFFFFC+4 wraps to 0.
- FSM states:
  - IDLE: on an accepted mispredict → REDIRECT at next edge; mispredict_cnt_o increments (wraps at 2^32).
  - REDIRECT: redirect_valid_o=1, flush_o=1, redirect_pc_o stable. Stays until redirect_ready=1. On that cycle:
    - FLUSH_CYCLES=1 → IDLE.
    - otherwise → DRAIN, with counter=FLUSH_CYCLES-1.
  - DRAIN: flush_o=1, redirect_valid_o=0. Counter decrements each cycle; → IDLE on the cycle the counter reads 1.
- Latency:
  - Mispredict seen at edge N → redirect_valid_o and flush_o high from cycle N+1.
  - With immediate ready and FLUSH_CYCLES=2, flush_o is high for exactly cycles N+1 and N+2; IDLE at N+3.
- busy_o = (state != IDLE).
- redirect_pc_o holds its last value after the handshake; consumers must qualify it with redirect_valid_o.

Test Plan:
- Reset then lookup_pc=0x100 → pred_taken_o=0. Three taken-branch resolves at res_pc=0x100 (pred matching) → counter 01→10→11→11; pred_taken_o=1 from the cycle after the 1st update; no flush.
- BEQ mispredict: res_pc=0x200, res_taken=1, res_target=0x180, res_pred_taken=0, redirect_ready=1 → redirect_valid_o one cycle with redirect_pc_o=0x180; flush_o 2 cycles; mispredict_cnt_o=1.
- Not-taken mispredict with redirect_ready held low 3 cycles: res_pc=0x300, res_taken=0, res_pred_taken=1 → redirect_pc_o=0x304, held stable with valid for 4 cycles; flush continues through DRAIN; busy_o high throughout.
- Target mismatch on JALR: taken, res_target=0x4000, res_pred_target=0x4004 → redirect to 0x4000; BHT unchanged (res_is_branch=0).
- res_valid mispredict pulses during REDIRECT/DRAIN → ignored: count unchanged, BHT unchanged, redirect_pc_o unchanged.
- Synchronous rst asserted while in REDIRECT → next cycle all outputs 0, counter 0, BHT entries back to 01.
